// File: rtl/piso_rr_scheduler.sv
// rtl/piso_rr_scheduler.sv - round-robin arbitrated LSB-first parallel-to-serial shifter
module piso_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     serial_o,
  output logic                     valid_o,
  output logic                     sof_o,
  output logic                     eof_o,
  output logic [ID_W-1:0]          src_o,
  output logic                     busy_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  src_q;
  logic [ID_W-1:0]  win;
  logic [ID_W-1:0]  ptr_nxt;
  logic             any_valid;
  logic             load_ok;
  logic             accept;
  int               idx;

  // Round-robin search starting at ptr; first valid requester wins.
  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && req_valid_i[idx]) begin
        any_valid = 1'b1;
        win       = idx[ID_W-1:0];
      end
    end
  end

  // Load window, grant and next-state decode (the eof cycle doubles as a load slot).
  always_comb begin
    load_ok     = (state == IDLE) || (cnt == LAST);
    accept      = load_ok && any_valid && !reset;
    req_ready_o = accept ? (NUM_REQ'(1) << win) : '0;
    ptr_nxt     = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    state_nxt   = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, shifter, bit counter, source tag and pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      src_q <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        shreg <= req_data_i[win*WIDTH +: WIDTH];
        cnt   <= '0;
        src_q <= win;
        ptr   <= ptr_nxt;
      end else if (state == SHIFT) begin
        if (cnt == LAST) begin
          shreg <= '0;
          cnt   <= '0;
        end else begin
          shreg <= shreg >> 1;
          cnt   <= cnt + 1'b1;
        end
      end
    end
  end

  // Serial outputs decode straight from registered state; shreg is zero when idle.
  always_comb begin
    valid_o  = (state == SHIFT);
    busy_o   = valid_o;
    serial_o = shreg[0];
    sof_o    = valid_o && (cnt == '0);
    eof_o    = valid_o && (cnt == LAST);
    src_o    = src_q;
  end

endmodule
